// File: rtl/jam_cost_table_if.sv
// Stream, lookup and status signals between the JAM cost table and its
// neighbours: the matrix feeder drives the stream, the engine drives W/J.
interface jam_cost_table_if #(
    parameter int CW  = 7,
    parameter int LBW = 10,
    parameter int WW  = 3
);
    logic           in_valid;
    logic [CW-1:0]  in_data;
    logic           in_ready;
    logic           reload;
    logic [WW-1:0]  W;
    logic [WW-1:0]  J;
    logic [CW-1:0]  Cost;
    logic           table_ready;
    logic [LBW-1:0] LowerBound;

    modport master (
        output in_valid, in_data, reload, W, J,
        input  in_ready, Cost, table_ready, LowerBound
    );

    modport slave (
        input  in_valid, in_data, reload, W, J,
        output in_ready, Cost, table_ready, LowerBound
    );
endinterface

// File: rtl/jam_cost_table.sv
// Cost-matrix store for the JAM engine: loads an N x N matrix row-major from
// a valid/ready stream, tracks each row's minimum while loading, then sums
// the minima into LowerBound. Lookups on Cost are purely combinational.
module jam_cost_table #(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int LBW = 10
) (
    input  logic               CLK,
    input  logic               RST,
    jam_cost_table_if.slave    bus
);
    localparam int WW = $clog2(N);
    localparam int IW = $clog2(N * N);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SUM  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [WW-1:0]  r_q, r_d;
    logic [LBW-1:0] lb_q, lb_d;
    logic           table_ready_q, table_ready_d;
    logic           in_ready_q, in_ready_d;
    logic [CW-1:0]  mem_q [N*N];
    logic [CW-1:0]  mem_d [N*N];
    logic [CW-1:0]  rowmin_q [N];
    logic [CW-1:0]  rowmin_d [N];

    logic           handshake;
    logic [WW-1:0]  cur_row;

    assign handshake = bus.in_valid & in_ready_q;
    assign cur_row   = idx_q[IW-1:WW];

    assign bus.in_ready    = in_ready_q;
    assign bus.table_ready = table_ready_q;
    assign bus.LowerBound  = lb_q;
    assign bus.Cost        = mem_q[{bus.W, bus.J}];

    // Next-state logic: load stream words, fold row minima, then sum them up
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        r_d           = r_q;
        lb_d          = lb_q;
        table_ready_d = table_ready_q;
        mem_d         = mem_q;
        rowmin_d      = rowmin_q;

        case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (bus.reload) begin
                    idx_d = '0;
                end else if (handshake) begin
                    mem_d[idx_q] = bus.in_data;
                    idx_d        = idx_q + IW'(1);
                    if (idx_q[WW-1:0] == '0) begin
                        rowmin_d[cur_row] = bus.in_data;
                    end else if (bus.in_data < rowmin_q[cur_row]) begin
                        rowmin_d[cur_row] = bus.in_data;
                    end
                    if (idx_q == IW'(N * N - 1)) begin
                        state_d = SUM;
                        lb_d    = '0;
                        r_d     = '0;
                    end
                end
            end
            SUM: begin
                if (bus.reload) begin
                    state_d       = LOAD;
                    idx_d         = '0;
                    table_ready_d = 1'b0;
                    lb_d          = '0;
                end else begin
                    lb_d = lb_q + LBW'(rowmin_q[r_q]);
                    r_d  = r_q + WW'(1);
                    if (r_q == WW'(N - 1)) begin
                        state_d       = DONE;
                        table_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.reload) begin
                    state_d       = LOAD;
                    idx_d         = '0;
                    table_ready_d = 1'b0;
                    lb_d          = '0;
                end
            end
        endcase

        in_ready_d = (state_d == LOAD);
    end

    // State, counters and status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            r_q           <= '0;
            lb_q          <= '0;
            table_ready_q <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            r_q           <= r_d;
            lb_q          <= lb_d;
            table_ready_q <= table_ready_d;
            in_ready_q    <= in_ready_d;
        end
    end

    // Cost table and per-row minimum storage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N * N; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                rowmin_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N * N; i++) begin
                mem_q[i] <= mem_d[i];
            end
            for (int i = 0; i < N; i++) begin
                rowmin_q[i] <= rowmin_d[i];
            end
        end
    end
endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream feeder for the JAM job-assignment engine.
- Accepts the 8x8 worker/job cost matrix as a serial 7-bit stream (valid/ready) and stores it.
- Serves the engine's (W,J) lookups combinationally on Cost, so the engine can sample Cost on the falling edge.
- While loading, tracks the minimum cost of each worker row. After the load it sums the row minima into a LowerBound the engine may use for pruning.
- Raises table_ready once the table and LowerBound are final.

Parameters:
N, 8, workers = jobs (matrix is N x N; W/J width = log2(N) = 3)
CW, 7, cost entry width
LBW, 10, LowerBound width (N * (2^CW - 1) = 1016 fits)

Ports:
CLK  input  1  clock
RST  input  1  reset; asynchronous, active-high
in_valid  input  1  stream word valid
in_data  input  CW  cost word, row-major: word k = cost(worker k/8, job k%8)
in_ready  output  1  block accepts a word this cycle
reload  input  1  single-cycle pulse; restart loading
W  input  3  worker index from engine
J  input  3  job index from engine
Cost  output  CW  cost(W,J), combinational from stored table
table_ready  output  1  table and LowerBound valid
LowerBound  output  LBW  sum over rows of the row minimum

Behaviour:
- Reset is asynchronous, active-high, clock CLK. Reset values:
  - all 64 entries = 0, so Cost = 0
  - in_ready = 0, table_ready = 0, LowerBound = 0
  - write index idx = 0, rowmin[0..7] = 0, state = IDLE
- States: IDLE, LOAD, SUM, DONE.
- IDLE: unconditional move to LOAD at the next edge.
- LOAD:
  - in_ready = 1 (registered: high throughout LOAD, low in all other states).
  - A handshake is in_valid & in_ready at a rising edge. On each handshake:
    - mem[idx] <= in_data; idx <= idx + 1.
    - If idx[2:0] == 0, rowmin[idx[5:3]] <= in_data; otherwise rowmin <= min(rowmin, in_data), unsigned compare.
  - in_valid low: no change. Gaps are allowed with unlimited length.
  - On the 64th handshake (idx == 63): go to SUM, clear LowerBound to 0, set row counter r = 0, drop in_ready.
- SUM:
  - At each edge: LowerBound <= LowerBound + rowmin[r] (zero-extended); r <= r + 1.
  - After the 8th add (r == 7), go to DONE and set table_ready <= 1 on the same edge.
  - Latency: if the 64th handshake is at edge E, table_ready = 1 and LowerBound is final after edge E+8.
- DONE:
  - Table holds; table_ready = 1; in_ready = 0.
  - in_valid is ignored and no write occurs.
- Cost:
  - Cost = mem[{W,J}] in every state, with no register stage.
  - Cost is only guaranteed meaningful while table_ready = 1.
  - A write to the addressed entry appears on Cost right after the write edge.
- reload:
  - In DONE or SUM: next edge goes to LOAD; idx <= 0, table_ready <= 0, LowerBound <= 0. Stored entries are kept until overwritten.
  - In LOAD: idx <= 0 and the load restarts. A handshake on the same edge as reload is discarded; reload has priority.
  - In IDLE: no effect beyond the normal move to LOAD.
- Arithmetic: LowerBound is accumulated at LBW bits with no overflow possible. rowmin entries are CW bits.
- Reset mid-load or mid-SUM: everything returns to its reset values immediately (asynchronous), and the load restarts from word 0.
- Engine coupling: the engine must be held in reset until table_ready = 1. The table never drives the engine's reset.

Test Plan:
- Load cost(r,c) = r+c with in_valid held high -> in_ready high for 64 cycles; table_ready rises 8 edges after the last handshake; LowerBound = 28; W=3, J=5 gives Cost = 8; W=7, J=7 gives Cost = 14.
- Same data with in_valid toggled pseudo-randomly (gaps of 0-5 cycles) -> identical table, LowerBound = 28; no word dropped or duplicated.
- All words = 127 -> LowerBound = 1016, with no overflow. Then rows where the min sits in the last column (row r: 100 for c < 7, r for c = 7) -> LowerBound = 28.
- After DONE, pulse reload, then load all-1s -> table_ready falls the next edge and in_ready rises; after the reload completes, LowerBound = 8 and Cost = 1 for every (W,J). in_valid asserted while in DONE is ignored.
- Assert RST after 30 handshakes -> in_ready = 0, Cost = 0, LowerBound = 0 immediately. A fresh full load then completes correctly (LowerBound = 28 for the r+c data).
- Pulse reload on the same edge as the 40th handshake -> that word is discarded and idx = 0; the following 64 words form the table.
